// File: rtl/replay_bar_ctrl_pkg.sv
// Shared game definitions: replay-prompt state encodings, bar geometry and renderer colours.
package replay_bar_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } replay_state_e;

  localparam logic [2:0] BAR_SEGMENTS = 3'd4;

  localparam logic [11:0] COLOUR_BG      = 12'h000;
  localparam logic [11:0] COLOUR_BAR_ON  = 12'h0F0;
  localparam logic [11:0] COLOUR_BAR_OFF = 12'h333;
  localparam logic [11:0] COLOUR_TEXT    = 12'hFFF;

  function automatic logic bar_full(input logic [2:0] level);
    return (level >= BAR_SEGMENTS);
  endfunction

endpackage

// File: rtl/replay_bar_ctrl_tick_divider.sv
// Free-running prescaler: one-cycle tick every PERIOD enabled cycles, sync clear restarts the count.
module tick_divider #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = en && !clr && (cnt_r == LAST);

  // period counter, wraps on the tick cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/replay_bar_ctrl.sv
// Replay prompt controller: loading bar countdown with confirm/cancel/timeout exits.
// Optional blinking REPLAY text enabled by defining REPLAY_BLINK_EN.
module replay_bar_ctrl
  import replay_bar_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEG = 6250000,
  parameter int unsigned BLINK_TICKS   = 3125000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  output logic [2:0] bar_level,
  output logic       active,
  output logic       blink,
  output logic       replay_pulse,
  output logic       exit_pulse
);

  replay_state_e state_r;
  logic [2:0]    bar_level_r;
  logic          active_r;
  logic          replay_r;
  logic          exit_r;

  logic start_acc_s;
  logic in_count_s;
  logic seg_tick_s;
  logic timeout_s;

  // start is ignored only in DONE; in COUNT it restarts the countdown
  assign start_acc_s = start && (state_r != DONE);
  assign in_count_s  = (state_r == COUNT);
  assign timeout_s   = seg_tick_s && bar_full(bar_level_r);

  tick_divider #(
    .PERIOD(TICKS_PER_SEG)
  ) u_seg_div (
    .clk  (clk),
    .reset(reset),
    .clr  (start_acc_s || !in_count_s),
    .en   (in_count_s),
    .tick (seg_tick_s)
  );

  // prompt FSM with registered bar level and exit pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      bar_level_r <= 3'd0;
      active_r    <= 1'b0;
      replay_r    <= 1'b0;
      exit_r      <= 1'b0;
    end else begin
      replay_r <= 1'b0;
      exit_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= COUNT;
            bar_level_r <= 3'd0;
            active_r    <= 1'b1;
          end else begin
            state_r  <= IDLE;
            active_r <= 1'b0;
          end
        end
        COUNT: begin
          if (start) begin
            bar_level_r <= 3'd0;
          end else if (btn_confirm) begin
            state_r     <= DONE;
            bar_level_r <= 3'd0;
            active_r    <= 1'b0;
            replay_r    <= 1'b1;
          end else if (btn_cancel || timeout_s) begin
            state_r     <= DONE;
            bar_level_r <= 3'd0;
            active_r    <= 1'b0;
            exit_r      <= 1'b1;
          end else if (seg_tick_s) begin
            bar_level_r <= bar_level_r + 3'd1;
          end else begin
            bar_level_r <= bar_level_r;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          bar_level_r <= 3'd0;
          active_r    <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          bar_level_r <= 3'd0;
          active_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bar_level    = bar_level_r;
  assign active       = active_r;
  assign replay_pulse = replay_r;
  assign exit_pulse   = exit_r;

`ifdef REPLAY_BLINK_EN
  logic blink_r;
  logic blink_tick_s;
  logic stay_count_s;

  // true when the next cycle is still in COUNT, i.e. the text stays on screen
  assign stay_count_s = start_acc_s ||
                        (in_count_s && !btn_confirm && !btn_cancel && !timeout_s);

  tick_divider #(
    .PERIOD(BLINK_TICKS)
  ) u_blink_div (
    .clk  (clk),
    .reset(reset),
    .clr  (start_acc_s || !in_count_s),
    .en   (in_count_s),
    .tick (blink_tick_s)
  );

  // blink phase restarts visible on every (re)entry to COUNT
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_r <= 1'b1;
    end else if (start_acc_s || !stay_count_s) begin
      blink_r <= 1'b1;
    end else if (blink_tick_s) begin
      blink_r <= ~blink_r;
    end else begin
      blink_r <= blink_r;
    end
  end

  assign blink = blink_r;
`else
  localparam logic BLINK_LEVEL = (BLINK_TICKS > 0) ? 1'b1 : 1'b1;
  assign blink = BLINK_LEVEL;
`endif

endmodule

// File: tb/tb_replay_bar_ctrl.sv
// Directed bench for replay_bar_ctrl with TICKS_PER_SEG=4, BLINK_TICKS=2.
module tb_replay_bar_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       btn_confirm;
  logic       btn_cancel;
  logic [2:0] bar_level;
  logic       active;
  logic       blink;
  logic       replay_pulse;
  logic       exit_pulse;

  int n_cmp = 0;
  int n_err = 0;

  replay_bar_ctrl #(
    .TICKS_PER_SEG(4),
    .BLINK_TICKS  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn_confirm (btn_confirm),
    .btn_cancel  (btn_cancel),
    .bar_level   (bar_level),
    .active      (active),
    .blink       (blink),
    .replay_pulse(replay_pulse),
    .exit_pulse  (exit_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic       c;
    logic       x;
    logic       r;
    logic [2:0] bar;
    logic       act;
    logic       rep;
    logic       ex;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic s, input logic c, input logic x, input logic r,
                              input logic [2:0] bar, input logic act, input logic rep,
                              input logic ex);
    vec_t v;
    v.s = s; v.c = c; v.x = x; v.r = r;
    v.bar = bar; v.act = act; v.rep = rep; v.ex = ex;
    return v;
  endfunction

  // drive one cycle of inputs, then land 1 time unit after the edge
  task automatic cyc(input logic s, input logic c, input logic x, input logic r);
    start = s; btn_confirm = c; btn_cancel = x; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [2:0] eb, input logic ea,
                     input logic er, input logic ee);
    n_cmp++;
    if ({bar_level, active, replay_pulse, exit_pulse} !== {eb, ea, er, ee}) begin
      n_err++;
      $display("FAIL %s: got bar=%0d act=%0b rep=%0b exit=%0b, want bar=%0d act=%0b rep=%0b exit=%0b",
               name, bar_level, active, replay_pulse, exit_pulse, eb, ea, er, ee);
    end
  endtask

  task automatic chk_blink(input string name, input logic eb);
    n_cmp++;
    if (blink !== eb) begin
      n_err++;
      $display("FAIL %s: got blink=%0b, want blink=%0b", name, blink, eb);
    end
  endtask

  function automatic logic exp_blink(input int k);
`ifdef REPLAY_BLINK_EN
    return (((k - 1) / 2) % 2) == 0;
`else
    return (k >= 0);
`endif
  endfunction

  initial begin
    // row i: inputs during cycle i, expected outputs in cycle i+1
    tbl[0] = mk(1, 0, 0, 0, 3'd0, 1, 0, 0);
    for (int k = 1;  k < 4;  k++) tbl[k] = mk(0, 0, 0, 0, 3'd0, 1, 0, 0);
    for (int k = 4;  k < 8;  k++) tbl[k] = mk(0, 0, 0, 0, 3'd1, 1, 0, 0);
    for (int k = 8;  k < 12; k++) tbl[k] = mk(0, 0, 0, 0, 3'd2, 1, 0, 0);
    for (int k = 12; k < 16; k++) tbl[k] = mk(0, 0, 0, 0, 3'd3, 1, 0, 0);
    for (int k = 16; k < 20; k++) tbl[k] = mk(0, 0, 0, 0, 3'd4, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 3'd0, 0, 0, 1);
    tbl[21] = mk(1, 1, 0, 0, 3'd0, 0, 0, 0);
    tbl[22] = mk(0, 0, 1, 0, 3'd0, 0, 0, 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    chk_blink("reset_blink", 1'b1);

    // timeout run, then buttons/start in DONE and IDLE ignored
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].s, tbl[i].c, tbl[i].x, tbl[i].r);
      chk($sformatf("timeout_cyc%0d", i + 1), tbl[i].bar, tbl[i].act, tbl[i].rep, tbl[i].ex);
    end

    // confirm at cycle 7
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("confirm_pre", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("confirm_pulse", 3'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("confirm_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // both buttons at cycle 6 resolve as confirm
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_btn", 3'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("both_after", 3'd0, 1'b0, 1'b0, 1'b0);

    // restart at cycle 10 (with confirm, which start overrides)
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    chk("restart_pre", 3'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_clr", 3'd0, 1'b1, 1'b0, 1'b0);
    idle(19);
    chk("restart_c30", 3'd4, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("restart_c31", 3'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("restart_c32", 3'd0, 1'b0, 1'b0, 1'b0);

    // reset mid-COUNT at cycle 12
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);
    chk("midrst_pre", 3'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_c13", 3'd0, 1'b0, 1'b0, 1'b0);
    chk_blink("midrst_blink", 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_c14", 3'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("midrst_c15", 3'd0, 1'b0, 1'b0, 1'b0);

    // blink while active, then cancel
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      chk_blink($sformatf("blink_c%0d", k), exp_blink(k));
      if (k < 7) idle(1);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cancel_pulse", 3'd0, 1'b0, 1'b0, 1'b1);
    chk_blink("cancel_blink", 1'b1);
    idle(1);
    chk("cancel_after", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
